// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_unit : single-outstanding instruction fetcher feeding a FIFO.
// Optional macro FETCH_ALIGN_CHECK_EN blocks misaligned fetches (fetch_err).
// Revision: 1.0
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pc,
   output logic              pc_next,
   input  logic              flush,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              fetch_err
);
   localparam int          AW       = $clog2(BUF_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(BUF_DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              drop_q, drop_d, err_q, err_d;
   logic [DATA_W-1:0] addr_q, addr_d, tag_q, tag_d;
   logic [DATA_W-1:0] hold_instr_q, hold_instr_d, hold_pc_q, hold_pc_d;
   logic [DATA_W-1:0] buf_instr_q [BUF_DEPTH];
   logic [DATA_W-1:0] buf_instr_d [BUF_DEPTH];
   logic [DATA_W-1:0] buf_pc_q    [BUF_DEPTH];
   logic [DATA_W-1:0] buf_pc_d    [BUF_DEPTH];
   logic              misaligned, can_issue, push, pop, buf_empty;

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned = (pc[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // At most one request is ever in flight, so a free slot in IDLE is a safe reservation.
   assign buf_empty = (count_q == '0);
   assign can_issue = (count_q < FULL_CNT) && !flush && !misaligned && !err_q;
   assign push      = (state_q == S_WAIT) && imem_rvalid && !drop_q && !flush;
   assign pop       = !buf_empty && instr_ready && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (can_issue) state_d = S_REQ;
         S_REQ: begin
            if (flush)         state_d = S_IDLE;
            else if (imem_gnt) state_d = S_WAIT;
         end
         S_WAIT:  if (imem_rvalid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state_q == S_REQ);
      pc_next   = (state_q == S_REQ) && imem_gnt && !flush;
      imem_addr = addr_q;
      fetch_err = err_q;
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      drop_d       = drop_q;
      err_d        = err_q;
      addr_d       = addr_q;
      tag_d        = tag_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      buf_instr_d  = buf_instr_q;
      buf_pc_d     = buf_pc_q;

      if (state_q == S_IDLE && can_issue) addr_d = pc;
      if (pc_next)                        tag_d  = addr_q;

      // A flush while waiting leaves the reply in flight; it must be swallowed.
      if (state_q == S_WAIT) begin
         if (imem_rvalid) drop_d = 1'b0;
         else if (flush)  drop_d = 1'b1;
      end

`ifdef FETCH_ALIGN_CHECK_EN
      if (flush)                                err_d = 1'b0;
      else if (state_q == S_IDLE && misaligned) err_d = 1'b1;
`else
      err_d = 1'b0;
`endif

      if (!buf_empty) begin
         hold_instr_d = buf_instr_q[rd_ptr_q];
         hold_pc_d    = buf_pc_q[rd_ptr_q];
      end

      if (push) begin
         buf_instr_d[wr_ptr_q] = imem_rdata;
         buf_pc_d[wr_ptr_q]    = tag_q;
         wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         drop_q       <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         tag_q        <= '0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         buf_instr_q  <= '{default: '0};
         buf_pc_q     <= '{default: '0};
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         drop_q       <= drop_d;
         err_q        <= err_d;
         addr_q       <= addr_d;
         tag_q        <= tag_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         buf_instr_q  <= buf_instr_d;
         buf_pc_q     <= buf_pc_d;
      end
   end

   // An empty buffer keeps presenting the last head seen.
   assign instr_valid = !buf_empty;
   assign instr       = buf_empty ? hold_instr_q : buf_instr_q[rd_ptr_q];
   assign instr_pc    = buf_empty ? hold_pc_q    : buf_pc_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit : randomized scoreboard bench with a behavioural
// program-counter / memory / fetch-stream model.
module tb_instr_fetch_unit;
   localparam int DATA_W    = 32;
   localparam int BUF_DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset, flush, gnt, rvalid, ready;
   logic [31:0] rdata;
   logic [31:0] pc_r;
   logic        pc_next, imem_req, instr_valid, fetch_err;
   logic [31:0] imem_addr, instr, instr_pc;

   always #5 clk = ~clk;

   instr_fetch_unit #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk(clk), .reset(reset), .pc(pc_r), .pc_next(pc_next), .flush(flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(gnt),
      .imem_rvalid(rvalid), .imem_rdata(rdata), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(ready), .fetch_err(fetch_err)
   );

   typedef struct { logic [31:0] d; logic [31:0] a; } ent_t;
   ent_t        exp_q[$];
   int          checks = 0, failures = 0, delivered = 0;
   bit          outst = 0, dropped = 0, adv_f = 0, err_exp = 0;
   logic [31:0] outst_addr = '0, last_d = '0, last_a = '0, flush_tgt = '0;
   int          rv_wait = 0;
   int          gnt_prob = 100, ready_prob = 100, spur_prob = 0, rv_min = 0, rv_max = 0;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: samples mid-cycle, predicts what the next edge does.
   always @(negedge clk) begin
      bit idle_now;
      if (!reset) begin
         chk("rst_ctrl", {28'd0, instr_valid, imem_req, pc_next, fetch_err}, 32'd0);
         chk("rst_data", instr | instr_pc | imem_addr, 32'd0);
         exp_q.delete();
         outst = 0; dropped = 0; err_exp = 0; adv_f = 0; last_d = '0; last_a = '0;
      end else begin
         idle_now = !imem_req && !outst;
         chk("valid", 32'(instr_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("instr", instr, exp_q[0].d);
            chk("instr_pc", instr_pc, exp_q[0].a);
            last_d = exp_q[0].d; last_a = exp_q[0].a;
         end else begin
            chk("hold_instr", instr, last_d);
            chk("hold_pc", instr_pc, last_a);
         end
         chk("pc_next", 32'(pc_next), 32'(imem_req && gnt && !flush));
         if (imem_req) begin
            chk("req_addr", imem_addr, pc_r);
            chk("req_single", 32'(outst), 32'd0);
            chk("req_room", 32'(exp_q.size() < BUF_DEPTH), 32'd1);
         end
         chk("fetch_err", 32'(fetch_err), 32'(err_exp));
         adv_f = 0;
         if (flush) begin
            exp_q.delete();
            if (outst) begin
               if (rvalid) begin outst = 0; dropped = 0; end
               else dropped = 1;
            end
            err_exp = 0;
         end else begin
            if (exp_q.size() != 0 && ready) begin
               void'(exp_q.pop_front());
               delivered++;
            end
            if (outst && rvalid) begin
               if (!dropped) exp_q.push_back('{d: mem_f(outst_addr), a: outst_addr});
               outst = 0; dropped = 0;
            end else if (imem_req && gnt) begin
               outst = 1; dropped = 0; outst_addr = pc_r; adv_f = 1;
               rv_wait = int'($urandom_range(rv_max, rv_min));
            end
`ifdef FETCH_ALIGN_CHECK_EN
            if (idle_now && pc_r[1:0] != 2'b00) err_exp = 1;
`else
            if (idle_now) err_exp = 0;
`endif
         end
      end
   end

   // Driver: program counter and memory responder, one cycle per call.
   task automatic step();
      @(posedge clk); #1;
      if (flush)      pc_r = flush_tgt;
      else if (adv_f) pc_r = pc_r + 32'd4;
      flush = 1'b0;
      gnt   = (int'($urandom_range(99, 0)) < gnt_prob);
      ready = (int'($urandom_range(99, 0)) < ready_prob);
      if (outst && rv_wait == 0) begin
         rvalid = 1'b1;
         rdata  = dropped ? 32'hDEADBEEF : mem_f(outst_addr);
      end else begin
         if (outst) rv_wait--;
         rvalid = !outst && (int'($urandom_range(99, 0)) < spur_prob);
         rdata  = 32'hDEADBEEF;
      end
   endtask

   // sel: 0 = instr_valid, 1 = pc_next, 2 = imem_req
   task automatic wait_for(input string name, input int sel, input int limit);
      bit seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         step();
         @(negedge clk);
         seen = (sel == 0) ? instr_valid : (sel == 1) ? pc_next : imem_req;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: run exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      reset = 1'b0; flush = 1'b0; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0;
      rdata = '0; pc_r = '0;
      repeat (3) step();

      // Zero-wait stream from pc 0
      step(); reset = 1'b1;
      step(); step(); @(negedge clk);
      chk("lat_early", 32'(instr_valid), 32'd0);
      step(); @(negedge clk);
      chk("lat_valid", 32'(instr_valid), 32'd1);
      chk("lat_pc", instr_pc, 32'h0);
      d0 = delivered;
      repeat (30) step();
      chk("stream_rate", 32'(delivered - d0 >= 9), 32'd1);

      // Back-pressure: buffer fills with 0x0/0x4, request stays low
      ready_prob = 0;
      step(); flush = 1'b1; flush_tgt = 32'h0;
      repeat (20) step();
      @(negedge clk);
      chk("full_noreq", 32'(imem_req), 32'd0);
      chk("full_head", instr_pc, 32'h0);
      chk("full_pc", pc_r, 32'h8);
      ready_prob = 100;
      step(); @(negedge clk);
      chk("drain_first", instr_pc, 32'h0);
      step(); @(negedge clk);
      chk("drain_second", instr_pc, 32'h4);
      wait_for("resume_seen", 1, 10);
      chk("resume_addr", imem_addr, 32'h8);

      // Grant withheld for 5 cycles
      gnt_prob = 0;
      step(); flush = 1'b1; flush_tgt = 32'h40;
      wait_for("stall_req_seen", 2, 10);
      for (int i = 0; i < 5; i++) begin
         step(); @(negedge clk);
         chk("stall_req", 32'(imem_req), 32'd1);
         chk("stall_addr", imem_addr, 32'h40);
         chk("stall_pcnext", 32'(pc_next), 32'd0);
      end
      gnt_prob = 100;
      wait_for("stall_deliver", 0, 20);
      chk("stall_first_pc", instr_pc, 32'h40);

      // Flush in WAIT, late reply is dropped
      rv_min = 4; rv_max = 4;
      wait_for("wflush_grant", 1, 20);
      step(); flush = 1'b1; flush_tgt = 32'h100;
      wait_for("wflush_deliver", 0, 30);
      chk("wflush_pc", instr_pc, 32'h100);
      chk("wflush_data", instr, mem_f(32'h100));

      // Reset during WAIT, stray rvalid after release
      rv_min = 3; rv_max = 3;
      wait_for("rst_grant", 1, 20);
      step(); reset = 1'b0;
      step(); step();
      step(); reset = 1'b1; rvalid = 1'b1; rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("rst_rel_valid", 32'(instr_valid), 32'd0);
      step(); @(negedge clk);
      chk("rst_late_rvalid", 32'(instr_valid), 32'd0);

      // Misaligned pc
      rv_min = 0; rv_max = 0;
      step(); flush = 1'b1; flush_tgt = 32'h6;
`ifdef FETCH_ALIGN_CHECK_EN
      repeat (4) step();
      @(negedge clk);
      chk("align_err", 32'(fetch_err), 32'd1);
      chk("align_noreq", 32'(imem_req), 32'd0);
      chk("align_nopc", 32'(pc_next), 32'd0);
      step(); flush = 1'b1; flush_tgt = 32'h0;
      step(); @(negedge clk);
      chk("align_clear", 32'(fetch_err), 32'd0);
`else
      wait_for("align_deliver", 0, 20);
      chk("align_pass_pc", instr_pc, 32'h6);
      chk("align_no_err", 32'(fetch_err), 32'd0);
`endif

      // Randomized traffic
      gnt_prob = 60; ready_prob = 60; spur_prob = 5; rv_min = 0; rv_max = 3;
      d0 = delivered;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (int'($urandom_range(99, 0)) < 3) begin
            flush = 1'b1;
            flush_tgt = ($urandom_range(1023, 0) << 2) |
                        (($urandom_range(9, 0) == 0) ? 32'd2 : 32'd0);
         end
         reset = ($urandom_range(299, 0) != 0);
      end
      step(); reset = 1'b1;
      repeat (4) step();
      chk("random_progress", 32'(delivered - d0 > 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DATA_W, default 32: instruction and address width.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pc  input  DATA_W  current fetch address from ProgramCounter.
REQ-006 pc_next  output  1  one-cycle strobe telling ProgramCounter to advance; asserted only in the cycle a request is granted.
REQ-007 flush  input  1  branch/jump redirect; discards all buffered and in-flight instructions.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  DATA_W  read address; equals pc while imem_req is high.
REQ-010 imem_gnt  input  1  memory accepted the request this cycle.
REQ-011 imem_rvalid  input  1  read data valid.
REQ-012 imem_rdata  input  DATA_W  read data.
REQ-013 instr  output  DATA_W  instruction at the buffer head.
REQ-014 instr_pc  output  DATA_W  address of instr.
REQ-015 instr_valid  output  1  buffer head holds a valid instruction.
REQ-016 instr_ready  input  1  decode consumes the head when instr_valid and instr_ready are both high.
REQ-017 fetch_err  output  1  misaligned-fetch flag (see Configuration).

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ (imem_req high, waiting for grant), WAIT (one request outstanding, waiting for rvalid).
REQ-019 IDLE->REQ when free slots exceed outstanding requests and flush is low.
REQ-020 REQ->WAIT on imem_gnt; pc_next pulses for exactly that cycle; the issued pc SHALL be captured as the tag.
REQ-021 WAIT->IDLE on imem_rvalid; {imem_rdata, tag} SHALL be written to the buffer tail in the same edge.
REQ-022 At most one memory request SHALL be outstanding; imem_req SHALL stay high and imem_addr stable until imem_gnt.
REQ-023 Minimum latency: pc presented in IDLE -> instr_valid 3 cycles later with zero-wait memory (IDLE, REQ+gnt, WAIT+rvalid, then visible).
REQ-024 The buffer is a BUF_DEPTH-entry FIFO with wrapping read/write pointers; simultaneous push and pop when full SHALL be allowed.
REQ-025 Full: no new request is issued; a slot reserved for an outstanding request SHALL never be overwritten.
REQ-026 Empty: instr_valid low; instr and instr_pc hold their last values.
REQ-027 Flush in IDLE or REQ: empty the buffer, drop imem_req, return to IDLE; pc_next SHALL not pulse even if imem_gnt is high that cycle.
REQ-028 Flush in WAIT: empty the buffer, set a drop flag; the next rvalid SHALL be discarded, then the FSM returns to IDLE.
REQ-029 Flush takes priority over a simultaneous push or pop.
REQ-030 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-031 While reset is low: state IDLE, buffer empty, pointers zero, drop flag clear.
REQ-032 While reset is low: instr_valid, imem_req, pc_next and fetch_err at 0; instr, instr_pc and imem_addr at 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the outstanding request; a late rvalid after release SHALL be ignored (REQ-030).

Configuration
REQ-034 Macro FETCH_ALIGN_CHECK_EN defined: in IDLE, pc[1:0]!=0 SHALL block the request and assert fetch_err, which stays high until flush or reset; pc_next is not pulsed.
REQ-035 Macro FETCH_ALIGN_CHECK_EN undefined: pc[1:0] SHALL be passed unchanged and fetch_err tied to 0.

Verification
REQ-036 Zero-wait memory, pc=0x0, instr_ready=1 -> instr_valid by cycle 3 with instr_pc=0x0; one pc_next pulse per instruction; sustained stream.
REQ-037 instr_ready=0, pcs 0x0/0x4/0x8 -> exactly BUF_DEPTH=2 instructions buffered, imem_req low; raise instr_ready -> 0x0 then 0x4 delivered, fetch of 0x8 resumes.
REQ-038 imem_gnt held low 5 cycles -> imem_req and imem_addr stable for all 5 cycles, no pc_next until grant.
REQ-039 Flush in WAIT, late rvalid with 0xDEADBEEF -> data discarded, instr_valid stays 0, next fetch uses new pc=0x100.
REQ-040 Reset low during WAIT, then rvalid after release -> all outputs 0, buffer empty, rvalid ignored.
REQ-041 With FETCH_ALIGN_CHECK_EN, pc=0x6 -> fetch_err=1, imem_req=0, pc_next=0; flush -> fetch_err clears.
